// File: rtl/tqv_spi_host.sv
// tqv_spi_host: SPI initiator for the TinyQV peripheral harness.
// Serialises one register read/write per request as a mode-0 frame.
module tqv_spi_host #(
  parameter int CLK_DIV  = 2,
  parameter int READ_GAP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_width,
  input  logic [5:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NB = 16 + READ_GAP + 32;
  localparam int BW = $clog2(NB + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_HEADER,
    S_GAP,
    S_DATA,
    S_HOLD,
    S_RECOVER
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [47:0]   sr_q, sr_d;
  logic [31:0]   rx_q, rx_d;
  logic          write_q, write_d;
  logic [1:0]    wc_q, wc_d;
  logic          cs_n_q, cs_n_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;

  logic [1:0]    wc_in;
  logic [31:0]   wal;
  logic [BW-1:0] nbits;
  logic [BW-1:0] gap_end;
  logic [BW-1:0] data_end;
  logic          div_end;

  assign div_end = (div_q == DW'(CLK_DIV - 1));
  assign gap_end = BW'(16 + READ_GAP);

  // Width code (3 folds to 2) and write data left-aligned for MSB-first
  always_comb begin
    wc_in = (req_width == 2'd3) ? 2'd2 : req_width;
    unique case (wc_in)
      2'd0:    wal = {req_wdata[7:0], 24'h0};
      2'd1:    wal = {req_wdata[15:0], 16'h0};
      default: wal = req_wdata;
    endcase
  end

  // Bit index at which the data phase of the latched request ends
  always_comb begin
    unique case (wc_q)
      2'd0:    nbits = BW'(8);
      2'd1:    nbits = BW'(16);
      default: nbits = BW'(32);
    endcase
    data_end = (write_q ? BW'(16) : gap_end) + nbits;
  end

  // State and registered-output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      rx_q        <= '0;
      write_q     <= 1'b0;
      wc_q        <= 2'd0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      rx_q        <= rx_d;
      write_q     <= write_d;
      wc_q        <= wc_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    rx_d        = rx_q;
    write_d     = write_q;
    wc_d        = wc_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    ready_d     = ready_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = S_LOAD;
          ready_d = 1'b0;
          write_d = req_write;
          wc_d    = wc_in;
          sr_d    = {req_write, wc_in, 5'b0,
                     2'b0, req_addr,
                     req_write ? wal : 32'h0};
          rx_d    = '0;
          bit_d   = '0;
          div_d   = '0;
        end
      end
      S_LOAD: begin
        state_d = S_SETUP;
        cs_n_d  = 1'b0;
        mosi_d  = sr_q[47];
        div_d   = '0;
      end
      S_SETUP: begin
        if (div_end) begin
          div_d   = '0;
          sck_d   = 1'b1;
          state_d = S_HEADER;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_HEADER, S_GAP, S_DATA: begin
        if (!div_end) begin
          div_d = div_q + DW'(1);
        end else if (sck_q) begin
          // falling edge: bit done, present the next one
          div_d  = '0;
          sck_d  = 1'b0;
          bit_d  = bit_q + BW'(1);
          sr_d   = {sr_q[46:0], 1'b0};
          mosi_d = sr_q[46];
        end else begin
          // end of low half: pick phase, then rise
          div_d = '0;
          if (state_q == S_HEADER && bit_q == BW'(16))
            state_d = write_q ? S_DATA : S_GAP;
          else if (state_q == S_GAP && bit_q == gap_end)
            state_d = S_DATA;
          else if (state_q == S_DATA && bit_q == data_end)
            state_d = S_HOLD;
          if (state_d != S_HOLD) begin
            sck_d = 1'b1;
            if (state_d == S_DATA)
              rx_d = {rx_q[30:0], spi_miso};
          end
        end
      end
      S_HOLD: begin
        if (div_end) begin
          div_d       = '0;
          state_d     = S_RECOVER;
          cs_n_d      = 1'b1;
          mosi_d      = 1'b0;
          rsp_valid_d = 1'b1;
          if (!write_q)
            rdata_d = rx_q;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_RECOVER: begin
        if (div_end) begin
          div_d   = '0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
    endcase
  end

  assign req_ready = ready_q;
  assign busy      = ~ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;

endmodule
